mem_two_writeback: RTL and testbench
====================================

Name: mem_two_writeback

Overview:
- Final memory-path pipeline stage, directly downstream of the Mem_1 data-memory stage.
- Consumes the oper/regdest/writereg/wbvalue bundle produced by Mem_1.
- Arbitrates the single register-file write port against the ALU writeback path, which has priority.
- Buffers displaced memory results in a small FIFO, back-pressures Mem_1 when the FIFO is full, and exports the newest pending result for bypass.

Parameters:
- DEPTH, 2, retire-FIFO entries (power of two, >=2)
- DATA_W, 32, writeback data width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m1_m2_oper  in  1  Mem_1 slot holds a live instruction
- m1_m2_regdest  in  5  destination register
- m1_m2_writereg  in  1  instruction writes a register
- m1_m2_wbvalue  in  DATA_W  loaded value
- alu_wb_valid  in  1  ALU path requests the write port
- alu_wb_regdest  in  5  ALU destination register
- alu_wb_value  in  DATA_W  ALU result
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  5  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- m2_stall  out  1  FIFO full; Mem_1 must hold (combinational from count)
- fwd_valid  out  1  a valid entry is pending in the FIFO
- fwd_regdest  out  5  regdest of the newest valid pending entry
- fwd_value  out  DATA_W  value of the newest valid pending entry

Behaviour:
- Reset (async, active-low): rf_we=0, rf_waddr=0, rf_wdata=0; FIFO emptied (count=0, all entries invalid); fwd_* = 0; m2_stall=0. Reset asserted mid-operation discards all queued entries; none are written.
- Definitions:
  - in_v = m1_m2_oper & m1_m2_writereg & (m1_m2_regdest != 0)
  - alu_v = alu_wb_valid & (alu_wb_regdest != 0)
  - Writes to r0 are discarded on both paths.
- Port selection, evaluated at each posedge, with rf_* updated at the same edge (1-cycle latency):
  1. alu_v: write the ALU triple.
  2. Else if count > 0: pop the head. If the head is valid, write it; if it was squashed, rf_we=0 this cycle.
  3. Else if in_v and not squashed: write the incoming triple directly (bypass; not enqueued).
  4. Else: rf_we=0; rf_waddr and rf_wdata hold.
- Enqueue: an incoming in_v entry that is not written directly and not squashed is pushed at the tail.
  - Push and pop in the same cycle are allowed; count is unchanged.
- Squash: when alu_v, the ALU instruction is younger than anything in this stage.
  - Every queued entry with regdest == alu_wb_regdest is marked invalid; it still occupies its slot.
  - An incoming entry with the same regdest in that cycle is dropped.
- Full (count == DEPTH):
  - m2_stall=1; Mem_1 holds its outputs.
  - An in_v arriving while full and with no simultaneous pop is dropped. Caller responsibility; see the optional feature.
  - If a pop happens in the same cycle, the push is accepted.
- Empty: no pop. fwd_valid=0 and fwd_regdest/fwd_value = 0.
- Read and write pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Forwarding:
  - fwd_* is combinational from current FIFO contents and selects the newest valid entry only.
  - An entry being written on rf_* this cycle is not reported; the register file handles that case.
- m1_m2_oper=0 is treated as a bubble, regardless of the other m1 fields.

Optional Feature:
- Macro: MEM_TWO_WB_STATS_EN.
- When defined, adds three outputs:
  - retire_count, 32-bit: increments on each rf_we=1 cycle sourced from the memory path (direct or pop); wraps at 2^32.
  - squash_count, 16-bit: increments on each squashed queued or incoming entry; saturates at 0xFFFF.
  - overflow, 1-bit sticky: set when an in_v is dropped due to full.
  - All three are cleared by reset.
- When not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then m1 entry (oper=1, writereg=1, regdest=5, wbvalue=0xDEADBEEF) with ALU idle -> next edge rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; FIFO stays empty.
- ALU (r3=0x11) and m1 (r7=0x22) in the same cycle -> cycle 1 writes r3/0x11, fwd_valid=1 (r7/0x22); cycle 2 writes r7/0x22, fwd_valid=0.
- ALU valid for 3 consecutive cycles while m1 sends r1..r3 -> after 2 pushes m2_stall=1; the third entry is dropped (overflow=1 with MEM_TWO_WB_STATS_EN); after ALU stops, r1 then r2 are written in order.
- Queue holds r9; ALU writes r9=0x55 -> the r9 entry is squashed; its pop cycle shows rf_we=0; squash_count=1.
- m1 regdest=0 with writereg=1, and oper=0 with regdest=4 -> no rf_we and no enqueue in either case.
- Assert reset low with 2 queued entries -> all outputs return to 0 immediately (async); no queued writes occur after release.

Source files
------------

// File: rtl/mem_two_writeback.sv
// Mem_2 writeback stage: arbitrates the register-file write port (ALU first), queues displaced
// memory results in a small retire FIFO and exports the newest pending one for bypass.
// Optional statistics outputs are enabled by defining MEM_TWO_WB_STATS_EN.
module mem_two_writeback #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m1_m2_oper,
  input  logic [4:0]        m1_m2_regdest,
  input  logic              m1_m2_writereg,
  input  logic [DATA_W-1:0] m1_m2_wbvalue,
  input  logic              alu_wb_valid,
  input  logic [4:0]        alu_wb_regdest,
  input  logic [DATA_W-1:0] alu_wb_value,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              m2_stall,
  output logic              fwd_valid,
  output logic [4:0]        fwd_regdest,
  output logic [DATA_W-1:0] fwd_value
`ifdef MEM_TWO_WB_STATS_EN
  ,
  output logic [31:0]       retire_count,
  output logic [15:0]       squash_count,
  output logic              overflow
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [4:0]        q_rd_r  [DEPTH];
  logic [DATA_W-1:0] q_val_r [DEPTH];
  logic [DEPTH-1:0]  q_ok_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;

  logic              in_v_s;
  logic              alu_v_s;
  logic              full_s;
  logic              empty_s;
  logic              squash_in_s;
  logic              pop_s;
  logic              direct_s;
  logic              push_s;
  logic              drop_full_s;
  logic [DEPTH-1:0]  sq_mask_s;
  logic              we_n_s;
  logic [4:0]        waddr_n_s;
  logic [DATA_W-1:0] wdata_n_s;
  logic              mem_ret_s;

  assign in_v_s      = m1_m2_oper & m1_m2_writereg & (m1_m2_regdest != 5'd0);
  assign alu_v_s     = alu_wb_valid & (alu_wb_regdest != 5'd0);
  assign full_s      = (count_r == CNT_W'(DEPTH));
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign squash_in_s = alu_v_s & in_v_s & (m1_m2_regdest == alu_wb_regdest);
  assign pop_s       = ~alu_v_s & ~empty_s;
  assign direct_s    = ~alu_v_s & empty_s & in_v_s;
  // A pop in the same cycle frees the slot, so a push into a full queue is still accepted
  assign push_s      = in_v_s & ~direct_s & ~squash_in_s & (~full_s | pop_s);
  assign drop_full_s = in_v_s & ~squash_in_s & full_s & ~pop_s;
  assign m2_stall    = full_s;

  // Per-entry squash match: the younger ALU write supersedes queued results for the same register
  always_comb begin
    sq_mask_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      sq_mask_s[i] = alu_v_s & q_ok_r[i] & (q_rd_r[i] == alu_wb_regdest);
    end
  end

  // Write-port arbitration: ALU, then FIFO head, then direct bypass of the incoming result
  always_comb begin
    we_n_s    = 1'b0;
    waddr_n_s = rf_waddr;
    wdata_n_s = rf_wdata;
    mem_ret_s = 1'b0;
    if (alu_v_s) begin
      we_n_s    = 1'b1;
      waddr_n_s = alu_wb_regdest;
      wdata_n_s = alu_wb_value;
    end else if (pop_s) begin
      if (q_ok_r[rd_ptr_r]) begin
        we_n_s    = 1'b1;
        waddr_n_s = q_rd_r[rd_ptr_r];
        wdata_n_s = q_val_r[rd_ptr_r];
        mem_ret_s = 1'b1;
      end else begin
        we_n_s = 1'b0;
      end
    end else if (direct_s) begin
      we_n_s    = 1'b1;
      waddr_n_s = m1_m2_regdest;
      wdata_n_s = m1_m2_wbvalue;
      mem_ret_s = 1'b1;
    end else begin
      we_n_s = 1'b0;
    end
  end

  // Register-file write port
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= 5'd0;
      rf_wdata <= {DATA_W{1'b0}};
    end else begin
      rf_we    <= we_n_s;
      rf_waddr <= waddr_n_s;
      rf_wdata <= wdata_n_s;
    end
  end

  // Retire FIFO storage, validity and pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_rd_r[i]  <= 5'd0;
        q_val_r[i] <= {DATA_W{1'b0}};
      end
      q_ok_r   <= {DEPTH{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_s && (wr_ptr_r == PTR_W'(i))) begin
          q_rd_r[i]  <= m1_m2_regdest;
          q_val_r[i] <= m1_m2_wbvalue;
          q_ok_r[i]  <= 1'b1;
        end else if (sq_mask_s[i] || (pop_s && (rd_ptr_r == PTR_W'(i)))) begin
          q_ok_r[i] <= 1'b0;
        end else begin
          q_ok_r[i] <= q_ok_r[i];
        end
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Bypass: walk back from the tail and report the newest still-valid entry
  always_comb begin
    logic [PTR_W-1:0] idx;
    logic             found;
    fwd_valid   = 1'b0;
    fwd_regdest = 5'd0;
    fwd_value   = {DATA_W{1'b0}};
    found       = 1'b0;
    idx         = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr_r - PTR_W'(i + 1);
      if (!found && (CNT_W'(i) < count_r) && q_ok_r[idx]) begin
        fwd_valid   = 1'b1;
        fwd_regdest = q_rd_r[idx];
        fwd_value   = q_val_r[idx];
        found       = 1'b1;
      end else begin
        found = found;
      end
    end
  end

`ifdef MEM_TWO_WB_STATS_EN
  logic [16:0] sq_sum_s;

  // Squash tally for this cycle, saturating at 16 bits
  always_comb begin
    sq_sum_s = {1'b0, squash_count} + {16'd0, squash_in_s};
    for (int i = 0; i < DEPTH; i++) begin
      sq_sum_s = sq_sum_s + {16'd0, sq_mask_s[i]};
    end
    if (sq_sum_s > 17'h0FFFF) begin
      sq_sum_s = 17'h0FFFF;
    end else begin
      sq_sum_s = sq_sum_s;
    end
  end

  // Statistics counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      retire_count <= 32'd0;
      squash_count <= 16'd0;
      overflow     <= 1'b0;
    end else begin
      retire_count <= retire_count + {31'd0, mem_ret_s};
      squash_count <= sq_sum_s[15:0];
      overflow     <= overflow | drop_full_s;
    end
  end
`else
  logic unused_stats_s;
  assign unused_stats_s = mem_ret_s ^ drop_full_s;
`endif

endmodule

// File: tb/tb_mem_two_writeback.sv
// Directed, table-driven bench for mem_two_writeback with hand-computed expectations,
// plus a hand-written asynchronous-reset-with-queued-entries sequence.
module tb_mem_two_writeback;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        m1_m2_oper = 1'b0;
  logic [4:0]  m1_m2_regdest = 5'd0;
  logic        m1_m2_writereg = 1'b0;
  logic [31:0] m1_m2_wbvalue = 32'd0;
  logic        alu_wb_valid = 1'b0;
  logic [4:0]  alu_wb_regdest = 5'd0;
  logic [31:0] alu_wb_value = 32'd0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        m2_stall;
  logic        fwd_valid;
  logic [4:0]  fwd_regdest;
  logic [31:0] fwd_value;
`ifdef MEM_TWO_WB_STATS_EN
  logic [31:0] retire_count;
  logic [15:0] squash_count;
  logic        overflow;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  mem_two_writeback #(.DEPTH(2), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .m1_m2_oper(m1_m2_oper), .m1_m2_regdest(m1_m2_regdest),
    .m1_m2_writereg(m1_m2_writereg), .m1_m2_wbvalue(m1_m2_wbvalue),
    .alu_wb_valid(alu_wb_valid), .alu_wb_regdest(alu_wb_regdest), .alu_wb_value(alu_wb_value),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .m2_stall(m2_stall),
    .fwd_valid(fwd_valid), .fwd_regdest(fwd_regdest), .fwd_value(fwd_value)
`ifdef MEM_TWO_WB_STATS_EN
    , .retire_count(retire_count), .squash_count(squash_count), .overflow(overflow)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        op;
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] wv;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] aval;
    logic [76:0] exp;  // {we, waddr, wdata, stall, fwd_valid, fwd_regdest, fwd_value}
  } vec_t;

  function automatic vec_t mk(input logic op, input logic wr, input logic [4:0] rd,
                              input logic [31:0] wv, input logic av, input logic [4:0] ard,
                              input logic [31:0] aval, input logic we, input logic [4:0] waddr,
                              input logic [31:0] wdata, input logic st, input logic fv,
                              input logic [4:0] frd, input logic [31:0] fval);
    vec_t v;
    v.op = op; v.wr = wr; v.rd = rd; v.wv = wv;
    v.av = av; v.ard = ard; v.aval = aval;
    v.exp = {we, waddr, wdata, st, fv, frd, fval};
    return v;
  endfunction

  function automatic logic [76:0] obs();
    return {rf_we, rf_waddr, rf_wdata, m2_stall, fwd_valid, fwd_regdest, fwd_value};
  endfunction

  task automatic check_now(input string nm, input logic [76:0] exp);
    logic [76:0] got;
    got = obs();
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got we/addr/data/stall/fv/frd/fval=%h want %h", nm, got, exp);
    end
  endtask

  task automatic apply(input vec_t v, input string nm);
    m1_m2_oper = v.op; m1_m2_writereg = v.wr; m1_m2_regdest = v.rd; m1_m2_wbvalue = v.wv;
    alu_wb_valid = v.av; alu_wb_regdest = v.ard; alu_wb_value = v.aval;
    @(posedge clock);
    #1;
    check_now(nm, v.exp);
  endtask

  task automatic check_stat(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  vec_t vecs[30];
  vec_t hs;

  initial begin
    vecs[0]  = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd0, 32'h0,        1'b0,1'b0,5'd0, 32'h0);
    vecs[1]  = mk(1'b1,1'b1,5'd5, 32'hDEADBEEF,1'b0,5'd0, 32'h0,  1'b1,5'd5, 32'hDEADBEEF, 1'b0,1'b0,5'd0, 32'h0);
    vecs[2]  = mk(1'b1,1'b1,5'd7, 32'h22,      1'b1,5'd3, 32'h11, 1'b1,5'd3, 32'h11,       1'b0,1'b1,5'd7, 32'h22);
    vecs[3]  = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd7, 32'h22,       1'b0,1'b0,5'd0, 32'h0);
    vecs[4]  = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd7, 32'h22,       1'b0,1'b0,5'd0, 32'h0);
    vecs[5]  = mk(1'b1,1'b1,5'd1, 32'h101,     1'b1,5'd10,32'hA0, 1'b1,5'd10,32'hA0,       1'b0,1'b1,5'd1, 32'h101);
    vecs[6]  = mk(1'b1,1'b1,5'd2, 32'h102,     1'b1,5'd11,32'hA1, 1'b1,5'd11,32'hA1,       1'b1,1'b1,5'd2, 32'h102);
    vecs[7]  = mk(1'b1,1'b1,5'd3, 32'h103,     1'b1,5'd12,32'hA2, 1'b1,5'd12,32'hA2,       1'b1,1'b1,5'd2, 32'h102);
    vecs[8]  = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd1, 32'h101,      1'b0,1'b1,5'd2, 32'h102);
    vecs[9]  = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd2, 32'h102,      1'b0,1'b0,5'd0, 32'h0);
    vecs[10] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd2, 32'h102,      1'b0,1'b0,5'd0, 32'h0);
    vecs[11] = mk(1'b1,1'b1,5'd9, 32'h99,      1'b1,5'd20,32'h20, 1'b1,5'd20,32'h20,       1'b0,1'b1,5'd9, 32'h99);
    vecs[12] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd9, 32'h55, 1'b1,5'd9, 32'h55,       1'b0,1'b0,5'd0, 32'h0);
    vecs[13] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd9, 32'h55,       1'b0,1'b0,5'd0, 32'h0);
    vecs[14] = mk(1'b1,1'b1,5'd6, 32'h77,      1'b1,5'd6, 32'h66, 1'b1,5'd6, 32'h66,       1'b0,1'b0,5'd0, 32'h0);
    vecs[15] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd6, 32'h66,       1'b0,1'b0,5'd0, 32'h0);
    vecs[16] = mk(1'b1,1'b1,5'd0, 32'h1234,    1'b0,5'd0, 32'h0,  1'b0,5'd6, 32'h66,       1'b0,1'b0,5'd0, 32'h0);
    vecs[17] = mk(1'b0,1'b1,5'd4, 32'h44,      1'b0,5'd0, 32'h0,  1'b0,5'd6, 32'h66,       1'b0,1'b0,5'd0, 32'h0);
    vecs[18] = mk(1'b1,1'b0,5'd4, 32'h45,      1'b0,5'd0, 32'h0,  1'b0,5'd6, 32'h66,       1'b0,1'b0,5'd0, 32'h0);
    vecs[19] = mk(1'b1,1'b1,5'd8, 32'h88,      1'b1,5'd0, 32'hBAD,1'b1,5'd8, 32'h88,       1'b0,1'b0,5'd0, 32'h0);
    vecs[20] = mk(1'b1,1'b1,5'd14,32'hE,       1'b1,5'd13,32'hD,  1'b1,5'd13,32'hD,        1'b0,1'b1,5'd14,32'hE);
    vecs[21] = mk(1'b1,1'b1,5'd16,32'h10,      1'b1,5'd15,32'hF,  1'b1,5'd15,32'hF,        1'b1,1'b1,5'd16,32'h10);
    vecs[22] = mk(1'b1,1'b1,5'd17,32'h11,      1'b0,5'd0, 32'h0,  1'b1,5'd14,32'hE,        1'b1,1'b1,5'd17,32'h11);
    vecs[23] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd16,32'h10,       1'b0,1'b1,5'd17,32'h11);
    vecs[24] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd17,32'h11,       1'b0,1'b0,5'd0, 32'h0);
    vecs[25] = mk(1'b1,1'b1,5'd22,32'h222,     1'b1,5'd21,32'h21, 1'b1,5'd21,32'h21,       1'b0,1'b1,5'd22,32'h222);
    vecs[26] = mk(1'b1,1'b1,5'd24,32'h224,     1'b1,5'd23,32'h23, 1'b1,5'd23,32'h23,       1'b1,1'b1,5'd24,32'h224);
    vecs[27] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd24,32'h55, 1'b1,5'd24,32'h55,       1'b1,1'b1,5'd22,32'h222);
    vecs[28] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b1,5'd22,32'h222,      1'b0,1'b0,5'd0, 32'h0);
    vecs[29] = mk(1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,  1'b0,5'd22,32'h222,      1'b0,1'b0,5'd0, 32'h0);

    #12;
    check_now("reset_state", 77'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 30; i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

`ifdef MEM_TWO_WB_STATS_EN
    check_stat("retire_count", retire_count, 32'd9);
    check_stat("squash_count", {16'd0, squash_count}, 32'd3);
    check_stat("overflow", {31'd0, overflow}, 32'd1);
`endif

    // Two entries queued, then reset asserted between clock edges
    hs = mk(1'b1,1'b1,5'd26,32'h26, 1'b1,5'd25,32'h25, 1'b1,5'd25,32'h25, 1'b0,1'b1,5'd26,32'h26);
    apply(hs, "rst_q1");
    hs = mk(1'b1,1'b1,5'd28,32'h28, 1'b1,5'd27,32'h27, 1'b1,5'd27,32'h27, 1'b1,1'b1,5'd28,32'h28);
    apply(hs, "rst_q2");
    m1_m2_oper = 1'b0; m1_m2_writereg = 1'b0; m1_m2_regdest = 5'd0; m1_m2_wbvalue = 32'd0;
    alu_wb_valid = 1'b0; alu_wb_regdest = 5'd0; alu_wb_value = 32'd0;
    #1;
    reset = 1'b0;
    #1;
    check_now("async_reset", 77'd0);
`ifdef MEM_TWO_WB_STATS_EN
    check_stat("stats_reset", retire_count | {16'd0, squash_count} | {31'd0, overflow}, 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_now($sformatf("post_reset%0d", i), 77'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
